int_event_queue: RTL

//   Interrupt source feeding the core's int/ioin/ioread interface. Peripherals push 8-bit event

---
 rtl/int_event_queue_if.sv | 28 ++
 rtl/int_event_queue.sv | 82 ++++++++
 2 files changed

// File: rtl/int_event_queue_if.sv
// Event-queue side of the core interrupt link: peripheral push port,
// core int/ioin/ioread port and overflow status.
interface int_event_queue_if #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             push;
   logic [WIDTH-1:0] push_data;
   logic             full;
   logic             int_req;
   logic [WIDTH-1:0] ioin;
   logic             ioread;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             clear_ovf;

   modport master (
      output push, push_data, ioread, clear_ovf,
      input  full, int_req, ioin, count, overflow
   );

   modport slave (
      input  push, push_data, ioread, clear_ovf,
      output full, int_req, ioin, count, overflow
   );
endinterface

// File: rtl/int_event_queue.sv
// Interrupt event FIFO feeding core int/ioin/ioread; sticky overflow.
// Define INTQ_DROP_OLDEST_EN to overwrite the oldest entry when full.
module int_event_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input logic clock,
   input logic reset,
   int_event_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;

   logic empty, is_full, pop, push_acc, ovf_evt;
   logic wr_en, rd_adv;

   assign empty   = (count_q == '0);
   assign is_full = (count_q == CW'(DEPTH));
   assign pop     = bus.ioread && !empty;
   // A pop frees a slot in the same edge, so push is taken even when full.
   assign push_acc = bus.push && (!is_full || pop);
   assign ovf_evt  = bus.push && is_full && !pop;

`ifdef INTQ_DROP_OLDEST_EN
   assign wr_en  = push_acc || ovf_evt;
   assign rd_adv = pop || ovf_evt;
`else
   assign wr_en  = push_acc;
   assign rd_adv = pop;
`endif

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = bus.push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd_adv) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case (1'b1)
         push_acc && !pop: count_d = count_q + CW'(1);
         !push_acc && pop: count_d = count_q - CW'(1);
         default:          count_d = count_q;
      endcase
      if (ovf_evt)            ovf_d = 1'b1;
      else if (bus.clear_ovf) ovf_d = 1'b0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign bus.int_req  = !empty;
   assign bus.full     = is_full;
   assign bus.count    = count_q;
   assign bus.overflow = ovf_q;
   assign bus.ioin     = empty ? '0 : mem_q[rd_ptr_q];
endmodule
